// File: rtl/main_memory.sv
// Word-addressed bus memory: completes each read/write LATENCY cycles after acceptance and holds functionComplete until both enables drop.
// Build option MAIN_MEMORY_ACCESS_COUNTERS_EN adds saturating readCount/writeCount ports.
module main_memory #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int SIZE_IN_WORDS = 65536,
   parameter int LATENCY       = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    dataOut,
   output logic [DATA_WIDTH-1:0]    dataIn,
   input  logic                     readEnabled,
   input  logic                     writeEnabled,
   output logic                     functionComplete
`ifdef MAIN_MEMORY_ACCESS_COUNTERS_EN
   ,
   output logic [31:0]              readCount,
   output logic [31:0]              writeCount
`endif
);

   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam int MEM_AW = (SIZE_IN_WORDS > 1) ? $clog2(SIZE_IN_WORDS) : 1;
   localparam logic [ADDRESS_WIDTH:0] SIZE_L = (ADDRESS_WIDTH + 1)'(SIZE_IN_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    op_wr_q, op_wr_d;
   logic                    fc_q, fc_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    commit;
   logic                    any_en;
   logic                    in_range;
   logic                    mem_we;
   logic [MEM_AW-1:0]       mem_idx;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic [DATA_WIDTH-1:0]   mem [SIZE_IN_WORDS] = '{default: '0};

   assign any_en   = readEnabled | writeEnabled;
   assign in_range = ({1'b0, address} < SIZE_L);
   assign mem_idx  = address[MEM_AW-1:0];
   assign rd_word  = in_range ? mem[mem_idx] : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      fc_d    = fc_q;
      data_d  = data_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_en) begin
               op_wr_d = writeEnabled;
               cnt_d   = CNT_LOAD;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!any_en) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // address/dataOut are only looked at on this edge
               commit  = 1'b1;
               if (!op_wr_q) data_d = rd_word;
               fc_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!any_en) begin
               fc_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            fc_d    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         fc_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         fc_q    <= fc_d;
         data_q  <= data_d;
      end
   end

   // Storage has no reset; a reset edge suppresses any pending commit.
   assign mem_we = commit & op_wr_q & in_range & ~reset;

   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_idx] <= dataOut;
   end

   assign dataIn           = data_q;
   assign functionComplete = fc_q;

`ifdef MAIN_MEMORY_ACCESS_COUNTERS_EN
   logic [31:0] read_count_q, read_count_d;
   logic [31:0] write_count_q, write_count_d;

   always_comb begin
      read_count_d  = read_count_q;
      write_count_d = write_count_q;
      if (commit && !op_wr_q && read_count_q != 32'hFFFF_FFFF)
         read_count_d = read_count_q + 32'd1;
      if (commit && op_wr_q && write_count_q != 32'hFFFF_FFFF)
         write_count_d = write_count_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         read_count_q  <= '0;
         write_count_q <= '0;
      end else begin
         read_count_q  <= read_count_d;
         write_count_q <= write_count_d;
      end
   end

   assign readCount  = read_count_q;
   assign writeCount = write_count_q;
`endif

endmodule
